// File: rtl/hazard_scheduler.sv
// -----------------------------------------------------------------------------
// hazard_scheduler
//
// Central pipeline controller for the pipelined NAND CPU. Each cycle it decides
// whether the instruction sitting in decode issues to the action stage, keeps a
// per-register (and processor-status) scoreboard of writes that are in flight
// between issue and writeback, and produces the stall/flush controls that gate
// the fetch/decode pipeline registers. It also sequences HALT: the halting
// instruction waits in decode until every outstanding write has retired, then
// the core parks in HALTED until resume.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   d_*                 decode-stage instruction attributes (valid, operand
//                       reads, destination write, ps read/write, halt)
//   a_branch_taken      action stage resolved a taken branch this cycle
//   wb_*                writeback-stage commit of a register and/or ps
//   resume              leave HALTED
//   issue               decode instruction advances to action this cycle
//   stall_fetch         hold fetch PC and the fetch/decode register
//   flush_decode        invalidate the fetch/decode register contents
//   halted              core is halted
//   sb_err              sticky scoreboard underflow/overflow error
// -----------------------------------------------------------------------------
module hazard_scheduler #(
  parameter  int NUM_REGS     = 16,
  parameter  int MAX_INFLIGHT = 3,
  parameter  int FLUSH_CYCLES = 1,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_valid,
  input  logic          d_ra_use,
  input  logic [AW-1:0] d_ra_addr,
  input  logic          d_rt_use,
  input  logic [AW-1:0] d_rt_addr,
  input  logic          d_reg_write,
  input  logic [AW-1:0] d_reg_addr,
  input  logic          d_ps_read,
  input  logic          d_ps_write,
  input  logic          d_halt,
  input  logic          a_branch_taken,
  input  logic          wb_valid,
  input  logic          wb_reg_write,
  input  logic [AW-1:0] wb_reg_addr,
  input  logic          wb_ps_write,
  input  logic          resume,
  output logic          issue,
  output logic          stall_fetch,
  output logic          flush_decode,
  output logic          halted,
  output logic          sb_err
);

  localparam int CW  = $clog2(MAX_INFLIGHT + 1);
  localparam int FCW = 3;

  localparam logic [CW-1:0]  SB_MAX     = CW'(MAX_INFLIGHT);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [FCW-1:0] r_flush_cnt;
  logic [FCW-1:0] w_flush_cnt_nxt;

  logic [CW-1:0]  r_pend     [NUM_REGS];
  logic [CW-1:0]  w_pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_reg_err;
  logic [CW-1:0]  r_ps_pend;
  logic [CW-1:0]  w_ps_pend_nxt;
  logic           w_ps_err;
  logic           r_sb_err;

  logic           w_hazard;
  logic           w_all_idle;
  logic           w_issue;
  logic           w_flush;
  logic           w_stall;

  // Next value of one scoreboard counter plus an error flag in the MSB.
  // A simultaneous increment and decrement cancel out; an increment at the
  // ceiling or a decrement at zero holds the counter and flags the error.
  function automatic logic [CW:0] sb_next(input logic [CW-1:0] cnt,
                                          input logic          inc,
                                          input logic          dec);
    logic [CW-1:0] nxt;
    logic          err;
    nxt = cnt;
    err = 1'b0;
    if (inc && !dec) begin
      if (cnt == SB_MAX) err = 1'b1;
      else               nxt = cnt + CW'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) err = 1'b1;
      else           nxt = cnt - CW'(1);
    end
    return {err, nxt};
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection from registered counters only: no bypass, so a consumer
  // waits until the cycle after its producer's writeback.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_hazard = (d_ra_use    && (r_pend[d_ra_addr]  != '0))
            || (d_rt_use    && (r_pend[d_rt_addr]  != '0))
            || (d_ps_read   && (r_ps_pend          != '0))
            || (d_reg_write && (r_pend[d_reg_addr] == SB_MAX))
            || (d_ps_write  && (r_ps_pend          == SB_MAX));
  end

  always_comb begin
    w_all_idle = (r_ps_pend == '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_pend[i] != '0) w_all_idle = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls. Outputs are forced low while reset is asserted so the
  // pipeline registers see a quiet controller regardless of decode inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_issue = (r_state == ST_RUN) && d_valid && !w_hazard
           && !a_branch_taken && !d_halt;
    // The resume term gives the one-cycle clean-restart flush on HALTED->RUN;
    // a branch seen while halted is stale and ignored.
    w_flush = (a_branch_taken && (r_state != ST_HALTED))
           || (r_state == ST_FLUSH)
           || ((r_state == ST_HALTED) && resume);
    w_stall = (d_valid && !w_issue && !w_flush)
           || (r_state == ST_HALTED) || (r_state == ST_DRAIN);
  end

  assign issue        = rst_n && w_issue;
  assign flush_decode = rst_n && w_flush;
  assign stall_fetch  = rst_n && w_stall;
  assign halted       = rst_n && (r_state == ST_HALTED);
  assign sb_err       = r_sb_err;

  // ---------------------------------------------------------------------------
  // Scoreboard next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      {w_reg_err[i], w_pend_nxt[i]} =
        sb_next(r_pend[i],
                w_issue && d_reg_write && (d_reg_addr == AW'(i)),
                wb_valid && wb_reg_write && (wb_reg_addr == AW'(i)));
    end
    {w_ps_err, w_ps_pend_nxt} = sb_next(r_ps_pend,
                                        w_issue && d_ps_write,
                                        wb_valid && wb_ps_write);
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_RUN: begin
        if (a_branch_taken) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (d_valid && d_halt && !w_hazard) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        // A further taken branch restarts the flush window.
        if (a_branch_taken) begin
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (r_flush_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
        end
      end
      ST_DRAIN: begin
        // The branch is older than the HALT waiting in decode, so it wins.
        if (a_branch_taken) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (w_all_idle && !wb_valid) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (resume) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_ps_pend   <= '0;
      r_sb_err    <= 1'b0;
      // NOTE: the scoreboard array is reset like any other register because a
      // stale nonzero count would stall the pipeline forever.
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_ps_pend   <= w_ps_pend_nxt;
      if ((|w_reg_err) || w_ps_err) r_sb_err <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= w_pend_nxt[i];
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hazard_scheduler
//
// Directed scenarios plus randomized traffic for hazard_scheduler, checked
// against a behavioural model that keeps pending-write counts as plain
// integers and tracks the controller mode with a remaining-flush-cycles count.
// -----------------------------------------------------------------------------
module tb_hazard_scheduler;

  localparam int NR = 16;
  localparam int MI = 3;
  localparam int FC = 2;
  localparam int AW = 4;

  localparam int M_RUN    = 0;
  localparam int M_FLUSH  = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_HALTED = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_valid, d_ra_use, d_rt_use, d_reg_write, d_ps_read, d_ps_write, d_halt;
  logic [AW-1:0] d_ra_addr, d_rt_addr, d_reg_addr, wb_reg_addr;
  logic          a_branch_taken, wb_valid, wb_reg_write, wb_ps_write, resume;
  logic          issue, stall_fetch, flush_decode, halted, sb_err;

  always #5 clk = ~clk;

  hazard_scheduler #(.NUM_REGS(NR), .MAX_INFLIGHT(MI), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_valid(d_valid), .d_ra_use(d_ra_use), .d_ra_addr(d_ra_addr),
    .d_rt_use(d_rt_use), .d_rt_addr(d_rt_addr),
    .d_reg_write(d_reg_write), .d_reg_addr(d_reg_addr),
    .d_ps_read(d_ps_read), .d_ps_write(d_ps_write), .d_halt(d_halt),
    .a_branch_taken(a_branch_taken),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr),
    .wb_ps_write(wb_ps_write), .resume(resume),
    .issue(issue), .stall_fetch(stall_fetch), .flush_decode(flush_decode),
    .halted(halted), .sb_err(sb_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_pend [NR];
  int m_ps;
  int m_mode;
  int m_left;
  bit m_err;

  // Outputs sampled by the most recent step
  logic s_issue, s_stall, s_flush, s_halted, s_err;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_pend[r] = 0;
    m_ps = 0; m_mode = M_RUN; m_left = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    d_valid = 0; d_ra_use = 0; d_rt_use = 0; d_reg_write = 0; d_ps_read = 0;
    d_ps_write = 0; d_halt = 0; d_ra_addr = 0; d_rt_addr = 0; d_reg_addr = 0;
    a_branch_taken = 0; wb_valid = 0; wb_reg_write = 0; wb_reg_addr = 0;
    wb_ps_write = 0; resume = 0;
  endtask

  task automatic set_dec(input logic ra_u, input int ra, input logic rt_u, input int rt,
                         input logic wr, input int rd);
    d_valid = 1; d_ra_use = ra_u; d_ra_addr = AW'(ra); d_rt_use = rt_u;
    d_rt_addr = AW'(rt); d_reg_write = wr; d_reg_addr = AW'(rd);
  endtask

  task automatic set_wb(input int rd);
    wb_valid = 1; wb_reg_write = 1; wb_reg_addr = AW'(rd);
  endtask

  // Called just after a negedge with inputs applied: compares the outputs
  // against the model, then advances the model across the next posedge.
  task automatic step(input string tag);
    bit haz, e_issue, e_flush, e_stall;
    int total;
    #2;
    haz = (d_ra_use && m_pend[d_ra_addr] > 0) || (d_rt_use && m_pend[d_rt_addr] > 0)
       || (d_ps_read && m_ps > 0)
       || (d_reg_write && m_pend[d_reg_addr] >= MI) || (d_ps_write && m_ps >= MI);
    e_issue = (m_mode == M_RUN) && d_valid && !haz && !a_branch_taken && !d_halt;
    e_flush = (a_branch_taken && m_mode != M_HALTED) || (m_mode == M_FLUSH)
           || (m_mode == M_HALTED && resume);
    e_stall = (d_valid && !e_issue && !e_flush) || m_mode == M_HALTED || m_mode == M_DRAIN;
    s_issue = issue; s_stall = stall_fetch; s_flush = flush_decode;
    s_halted = halted; s_err = sb_err;
    check({tag, "_issue"},  32'(issue),        32'(e_issue));
    check({tag, "_stall"},  32'(stall_fetch),  32'(e_stall));
    check({tag, "_flush"},  32'(flush_decode), 32'(e_flush));
    check({tag, "_halted"}, 32'(halted),       32'(m_mode == M_HALTED));
    check({tag, "_sberr"},  32'(sb_err),       32'(m_err));
    @(posedge clk);
    total = m_ps;
    for (int r = 0; r < NR; r++) total += m_pend[r];
    case (m_mode)
      M_RUN:
        if (a_branch_taken) begin m_mode = M_FLUSH; m_left = FC; end
        else if (d_valid && d_halt && !haz) m_mode = M_DRAIN;
      M_FLUSH:
        if (a_branch_taken) m_left = FC;
        else begin
          m_left--;
          if (m_left == 0) m_mode = M_RUN;
        end
      M_DRAIN:
        if (a_branch_taken) begin m_mode = M_FLUSH; m_left = FC; end
        else if (total == 0 && !wb_valid) m_mode = M_HALTED;
      default:
        if (resume) m_mode = M_RUN;
    endcase
    for (int r = 0; r < NR; r++) begin
      int delta;
      delta = int'(e_issue && d_reg_write && d_reg_addr == AW'(r))
            - int'(wb_valid && wb_reg_write && wb_reg_addr == AW'(r));
      if ((delta > 0 && m_pend[r] == MI) || (delta < 0 && m_pend[r] == 0)) m_err = 1;
      else m_pend[r] += delta;
    end
    begin
      int dps;
      dps = int'(e_issue && d_ps_write) - int'(wb_valid && wb_ps_write);
      if ((dps > 0 && m_ps == MI) || (dps < 0 && m_ps == 0)) m_err = 1;
      else m_ps += dps;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    // Reset state, with busy inputs that would otherwise drive the controls.
    d_valid = 1; a_branch_taken = 1;
    #12;
    check("rst_issue", 32'(issue), 0);
    check("rst_flush", 32'(flush_decode), 0);
    check("rst_stall", 32'(stall_fetch), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_sberr", 32'(sb_err), 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // RAW on r3: producer issues, consumer waits until after writeback.
    set_dec(1, 1, 1, 2, 1, 3); step("raw_prod");
    check("raw_prod_issue", 32'(s_issue), 1);
    for (int k = 0; k < 3; k++) begin
      set_dec(1, 3, 0, 0, 1, 4); step("raw_wait");
      check("raw_wait_issue", 32'(s_issue), 0);
      check("raw_wait_stall", 32'(s_stall), 1);
    end
    set_dec(1, 3, 0, 0, 1, 4); set_wb(3); step("raw_wb");
    check("raw_wb_issue", 32'(s_issue), 0);
    set_dec(1, 3, 0, 0, 1, 4); step("raw_go");
    check("raw_go_issue", 32'(s_issue), 1);
    set_wb(4); step("raw_ret");

    // Same-cycle increment and decrement of r5.
    set_dec(0, 0, 0, 0, 1, 5); step("same_a");
    set_dec(0, 0, 0, 0, 1, 5); set_wb(5); step("same_b");
    set_dec(1, 5, 0, 0, 0, 0); step("same_read");
    check("same_pend_still1", 32'(s_issue), 0);
    set_wb(5); step("same_ret");
    set_dec(1, 5, 0, 0, 0, 0); step("same_read2");
    check("same_read2_issue", 32'(s_issue), 1);
    check("same_sberr", 32'(s_err), 0);

    // Taken branch: flush for the branch cycle plus FC FLUSH cycles.
    set_dec(0, 0, 0, 0, 1, 6); a_branch_taken = 1; step("br0");
    check("br0_issue", 32'(s_issue), 0);
    check("br0_flush", 32'(s_flush), 1);
    for (int k = 0; k < FC; k++) begin
      set_dec(0, 0, 0, 0, 1, 6); step("brf");
      check("brf_flush", 32'(s_flush), 1);
      check("brf_issue", 32'(s_issue), 0);
    end
    set_dec(0, 0, 0, 0, 0, 0); step("br_run");
    check("br_run_issue", 32'(s_issue), 1);
    check("br_run_flush", 32'(s_flush), 0);

    // HALT with two writes in flight.
    set_dec(0, 0, 0, 0, 1, 8); step("h_w8");
    set_dec(0, 0, 0, 0, 1, 9); step("h_w9");
    set_dec(0, 0, 0, 0, 0, 0); d_halt = 1; step("h_dec");
    check("h_dec_issue", 32'(s_issue), 0);
    set_dec(0, 0, 0, 0, 0, 0); d_halt = 1; set_wb(8); step("h_d1");
    check("h_d1_stall", 32'(s_stall), 1);
    set_dec(0, 0, 0, 0, 0, 0); d_halt = 1; set_wb(9); step("h_d2");
    set_dec(0, 0, 0, 0, 0, 0); d_halt = 1; step("h_d3");
    check("h_d3_halted", 32'(s_halted), 0);
    step("h_halt");
    check("h_halt_halted", 32'(s_halted), 1);
    resume = 1; step("h_resume");
    check("h_resume_flush", 32'(s_flush), 1);
    step("h_after");
    check("h_after_flush", 32'(s_flush), 0);
    check("h_after_halted", 32'(s_halted), 0);

    // HALT squashed by an older branch while draining.
    set_dec(0, 0, 0, 0, 1, 2); step("sq_w");
    set_dec(0, 0, 0, 0, 0, 0); d_halt = 1; step("sq_halt");
    set_dec(0, 0, 0, 0, 0, 0); d_halt = 1; a_branch_taken = 1; set_wb(2); step("sq_br");
    check("sq_br_flush", 32'(s_flush), 1);
    for (int k = 0; k < FC + 3; k++) begin
      step("sq_run");
      check("sq_never_halted", 32'(s_halted), 0);
    end

    // Randomized traffic with legal writebacks.
    for (int n = 0; n < 3000; n++) begin
      int r;
      d_valid     = ($urandom_range(0, 3) != 0);
      d_ra_use    = $urandom_range(0, 1);
      d_ra_addr   = AW'($urandom_range(0, NR - 1));
      d_rt_use    = $urandom_range(0, 1);
      d_rt_addr   = AW'($urandom_range(0, NR - 1));
      d_reg_write = $urandom_range(0, 1);
      d_reg_addr  = AW'($urandom_range(0, 3));
      d_ps_read   = ($urandom_range(0, 3) == 0);
      d_ps_write  = ($urandom_range(0, 3) == 0);
      d_halt      = ($urandom_range(0, 40) == 0);
      a_branch_taken = ($urandom_range(0, 15) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      wb_valid    = ($urandom_range(0, 1) == 0);
      r = $urandom_range(0, NR - 1);
      if (wb_valid && m_pend[r] > 0) begin
        wb_reg_write = 1; wb_reg_addr = AW'(r);
      end
      wb_ps_write = wb_valid && m_ps > 0 && ($urandom_range(0, 1) == 0);
      step("rnd");
    end

    // Underflow sets a sticky error; async reset clears everything.
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      if (m_mode == M_HALTED) resume = 1;
      step("quiesce");
    end
    set_dec(0, 0, 0, 0, 1, 10); step("e_w10");
    set_wb(7); step("e_under");
    check("e_under_before", 32'(s_err), 0);
    step("e_sticky1");
    check("e_sticky1", 32'(s_err), 1);
    step("e_sticky2");
    check("e_sticky2", 32'(s_err), 1);
    set_dec(1, 10, 0, 0, 0, 0); a_branch_taken = 1;
    #3 rst_n = 0;
    #1;
    check("arst_sberr", 32'(sb_err), 0);
    check("arst_issue", 32'(issue), 0);
    check("arst_flush", 32'(flush_decode), 0);
    check("arst_stall", 32'(stall_fetch), 0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    @(negedge clk);
    idle_inputs();
    set_dec(1, 10, 0, 0, 0, 0); step("arst_read10");
    check("arst_pend_cleared", 32'(s_issue), 1);
    check("arst_sberr_low", 32'(s_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
